mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Two-requester arbiter and access sequencer for port A of the memory map (block RAM plus the memory-mapped IO window).
- Shares the single port between requester 0 (CPU load/store unit) and requester 1 (display/IO fetch engine) using round-robin.
- Sequences each access through issue, read-latency wait and completion, then returns read data to the owning requester with a one-cycle done pulse.

Parameters:
DATA_WIDTH, 16, width of data words
ADDR_WIDTH, 16, width of memory addresses
RD_LATENCY, 1, cycles from the issue edge until mem_rdata is valid; legal range 1..3

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous active-low reset (reset==0 resets at posedge clk)
req0  input  1  requester 0 access request; held until done0
we0  input  1  requester 0 write enable (1=store, 0=load)
addr0  input  ADDR_WIDTH  requester 0 address
wdata0  input  DATA_WIDTH  requester 0 store data
gnt0  output  1  requester 0 owns the port (ISSUE/WAIT/DONE)
done0  output  1  one-cycle completion pulse for requester 0
rdata0  output  DATA_WIDTH  requester 0 load data, valid while done0=1
req1, we1, addr1, wdata1, gnt1, done1, rdata1: same as above, for requester 1
mem_addr  output  ADDR_WIDTH  to memory port A address
mem_wdata  output  DATA_WIDTH  to memory port A write data
mem_write  output  1  to memory port A write strobe
mem_rdata  input  DATA_WIDTH  from memory port A read data

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous and active-low.
  - reset==0 at a posedge forces state=IDLE, last_owner=1, all gnt/done=0, mem_write=0, mem_addr=0, mem_wdata=0, rdata0=rdata1=0.
  - Reset during ISSUE or WAIT abandons the access. No done is generated. mem_write is 0 from the cycle after that edge.
- State machine, states IDLE, ISSUE, WAIT, DONE:
  - IDLE:
    - If neither request is asserted, stay in IDLE.
    - If exactly one request is asserted, that requester becomes owner.
    - If both are asserted, owner = !last_owner (round-robin). After reset, requester 0 wins the first tie.
    - On grant: latch we, addr and wdata into mem_* registers, mem_write=we of the owner, last_owner=owner, go to ISSUE.
  - ISSUE (exactly 1 cycle):
    - mem_* are stable; the memory captures them at the end of this cycle.
    - Next state: write goes to DONE; read goes to WAIT with wait_cnt=RD_LATENCY-1.
    - mem_write is cleared at the ISSUE->next edge.
  - WAIT:
    - Decrement wait_cnt each cycle.
    - When wait_cnt==0, capture mem_rdata into rdata_owner and go to DONE.
  - DONE (1 cycle):
    - done_owner=1. gnt_owner stays 1.
    - Next state is IDLE. Arbitration resumes in IDLE, so the minimum gap between accesses is 1 cycle.
- Latency, counted from the edge that samples req in IDLE:
  - Write: done 2 cycles later.
  - Read: done 2+RD_LATENCY cycles later.
- gnt and done:
  - gnt0 and gnt1 are never both 1.
  - done is asserted only together with the matching gnt.
- Requester rules:
  - The requester holds req, we, addr and wdata until done. Address and data are latched at grant, so later changes are ignored.
  - Dropping req after grant does not cancel the access; done is still pulsed.
  - If req is still high after done, it is treated as a new request in IDLE.
- rdata hold: rdata_k holds its last value until the next read by the same requester. rdata_k is not updated on writes.
- Outputs mem_addr and mem_wdata hold their last value outside ISSUE. mem_write=0 in every state except ISSUE.
- IO window: addresses with addr[ADDR_WIDTH-1:9]!=0 are passed through unchanged. IO decoding stays downstream.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3), IO window boundary bit (9), RD_LATENCY legal range.
- One natural sub-module: rr_arbiter2. It is purely combinational: inputs req0, req1, last_owner; outputs valid and owner. The FSM and datapath stay in the top module.

Test Plan:
- Write then read, single requester: reset low for 2 cycles. req0=1, we0=1, addr0=16'h0010, wdata0=16'hBEEF → mem_write=1 for exactly 1 cycle with mem_addr=16'h0010, done0 pulses 2 cycles after grant. Then read 16'h0010 → rdata0=16'hBEEF with done0 at +3 cycles.
- Tie after reset: req0=req1=1, both reads → requester 0 granted first, requester 1 next. Keeping both requests high gives the order 0,1,0,1 and gnt0&gnt1 is never 1.
- Request dropped after grant: requester 1 drops req1 during WAIT → done1 is still pulsed. rdata1 = memory contents, and requester 0 is not granted until IDLE.
- Reset mid-operation: reset=0 during WAIT of a read → the next cycle is IDLE with done0=done1=0 and mem_write=0. No done appears afterwards.
- Latency sweep: RD_LATENCY=3, read of 16'h0200 (IO window) with mem_rdata driven to 16'h00A5 → done0 exactly 5 cycles after sampling, rdata0=16'h00A5.
- Latched inputs: change addr0 and wdata0 during ISSUE → memory sees only the values latched at grant.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the port-A arbiter/sequencer.
//   state_e      : sequencer state encoding
//   IoWindowBit  : lowest address bit that selects the memory-mapped IO window
//   RdLatency*   : supported range of memory read latency
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Addresses with any bit at or above this one fall in the IO window. They are
  // forwarded untouched; IO decode lives downstream of the port.
  localparam int unsigned IoWindowBit = 9;

  localparam int unsigned RdLatencyMin = 1;
  localparam int unsigned RdLatencyMax = 3;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick, purely combinational.
//   req0, req1 : pending requests
//   last_owner : requester granted most recently
//   valid      : at least one request pending
//   owner      : chosen requester (0 or 1), meaningful only when valid
module rr_arbiter2 (
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic valid,
  output logic owner
);

  always_comb begin
    valid = req0 | req1;
    // On a tie, hand the port to whoever did not have it last.
    if (req0 && req1) begin
      owner = ~last_owner;
    end else begin
      owner = req1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter and access sequencer for memory port A, shared by the CPU load/store
// unit (requester 0) and the display/IO fetch engine (requester 1).
//   clk, reset            : clock, synchronous active-low reset
//   reqN/weN/addrN/wdataN : requester N access (held until doneN)
//   gntN                  : requester N owns the port (issue, wait, done)
//   doneN                 : one-cycle completion pulse; rdataN valid with it
//   mem_addr/mem_wdata/mem_write : to port A, stable through the issue cycle
//   mem_rdata             : from port A, valid RD_LATENCY cycles after issue
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  done0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // Out-of-range latencies are clamped to the nearest supported value.
  localparam int unsigned RdLat = (RD_LATENCY < RdLatencyMin) ? RdLatencyMin :
                                  (RD_LATENCY > RdLatencyMax) ? RdLatencyMax : RD_LATENCY;
  localparam logic [1:0]  WaitInit = 2'(RdLat - 1);

  state_e                state_q;
  logic                  owner_q;
  logic                  last_owner_q;
  logic [1:0]            wait_cnt_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  mem_write_q;
  logic                  gnt0_q, gnt1_q;
  logic                  done0_q, done1_q;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

  logic arb_valid;
  logic arb_owner;

  rr_arbiter2 u_rr_arbiter2 (
    .req0       (req0),
    .req1       (req1),
    .last_owner (last_owner_q),
    .valid      (arb_valid),
    .owner      (arb_owner)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;  // gives requester 0 the first tie
      wait_cnt_q   <= 2'd0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_write_q  <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arb_valid) begin
            owner_q      <= arb_owner;
            last_owner_q <= arb_owner;
            mem_addr_q   <= arb_owner ? addr1 : addr0;
            mem_wdata_q  <= arb_owner ? wdata1 : wdata0;
            mem_write_q  <= arb_owner ? we1 : we0;
            gnt0_q       <= ~arb_owner;
            gnt1_q       <= arb_owner;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          // mem_write_q still holds the owner's we for this single cycle.
          mem_write_q <= 1'b0;
          if (mem_write_q) begin
            done0_q <= ~owner_q;
            done1_q <= owner_q;
            state_q <= StDone;
          end else begin
            wait_cnt_q <= WaitInit;
            state_q    <= StWait;
          end
        end
        StWait: begin
          if (wait_cnt_q == 2'd0) begin
            if (owner_q) begin
              rdata1_q <= mem_rdata;
              done1_q  <= 1'b1;
            end else begin
              rdata0_q <= mem_rdata;
              done0_q  <= 1'b1;
            end
            state_q <= StDone;
          end else begin
            wait_cnt_q <= wait_cnt_q - 2'd1;
          end
        end
        StDone: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_write = mem_write_q;

endmodule
